// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: word width, default polynomial, FSM state codes and
// the word-advance and popcount helpers used by both link ends.
package prbs_pkg;

    localparam int W            = 48;
    localparam int PRBS_ORD_DEF = 7;
    localparam int PRBS_TAP_DEF = 6;

    localparam logic ST_HUNT = 1'b0;
    localparam logic ST_LOCK = 1'b1;

    // The word following x: bit i of the new word is the XOR of the bits ord and
    // tap positions earlier in time, walking from the oldest bit (W-1) to the newest (0).
    function automatic logic [W-1:0] prbs_next_word(input logic [W-1:0] x,
                                                   input int ord, input int tap);
        logic [2*W-1:0] h;
        h = {x, {W{1'b0}}};
        for (int i = W - 1; i >= 0; i--) begin
            h[i] = h[i+ord] ^ h[i+tap];
        end
        return h[W-1:0];
    endfunction

    function automatic logic [5:0] popcount(input logic [W-1:0] x);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < W; i++) begin
            n = n + 6'(x[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/prbs_next_word.sv
// Combinational one-word advance of the PRBS sequence.
module prbs_next_word #(
    parameter int PRBS_ORD = prbs_pkg::PRBS_ORD_DEF,
    parameter int PRBS_TAP = prbs_pkg::PRBS_TAP_DEF
) (
    input  logic [prbs_pkg::W-1:0] cur_i,
    output logic [prbs_pkg::W-1:0] next_o
);

    assign next_o = prbs_pkg::prbs_next_word(cur_i, PRBS_ORD, PRBS_TAP);

endmodule

// File: rtl/prbs_rx_checker.sv
// Self-synchronising PRBS word checker: hunts for lock on consecutive predictable
// words, then compares each word to a free-running local reference.
module prbs_rx_checker
    import prbs_pkg::*;
#(
    parameter int PRBS_ORD   = PRBS_ORD_DEF,
    parameter int PRBS_TAP   = PRBS_TAP_DEF,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [W-1:0]     data_in_i,
    input  logic             valid_i,
    input  logic             clr_cnt_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [5:0]       err_bits_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] word_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [3:0]       LOCK_RUN = 4'(LOCK_CNT);
    localparam logic [3:0]       BAD_RUN  = 4'(UNLOCK_CNT);

    logic             state_q, state_d;
    logic [3:0]       good_q, good_d;
    logic [3:0]       bad_q, bad_d;
    logic [W-1:0]     prev_q, prev_d;
    logic [W-1:0]     ref_q, ref_d;
    logic             err_q, err_d;
    logic [5:0]       err_bits_q, err_bits_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

    logic [W-1:0]     cur_word;
    logic [W-1:0]     exp_word;
    logic [W-1:0]     diff;
    logic [5:0]       pop;
    logic [CNT_W+5:0] err_sum;
    logic             match;

    // One sequence advancer serves both states: predict from the last received
    // word while hunting, from the local reference once locked.
    assign cur_word = (state_q == ST_LOCK) ? ref_q : prev_q;

    prbs_next_word #(
        .PRBS_ORD(PRBS_ORD),
        .PRBS_TAP(PRBS_TAP)
    ) u_next (
        .cur_i (cur_word),
        .next_o(exp_word)
    );

    assign diff    = data_in_i ^ exp_word;
    assign pop     = popcount(diff);
    assign match   = (diff == '0) && (data_in_i != '0);
    assign err_sum = {6'b0, err_cnt_q} + {{CNT_W{1'b0}}, pop};

    // NOTE: every next-state signal gets its default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        good_d     = good_q;
        bad_d      = bad_q;
        prev_d     = prev_q;
        ref_d      = ref_q;
        err_d      = 1'b0;
        err_bits_d = err_bits_q;
        err_cnt_d  = err_cnt_q;
        word_cnt_d = word_cnt_q;

        if (valid_i) begin
            if (state_q == ST_HUNT) begin
                prev_d = data_in_i;
                good_d = match ? good_q + 4'd1 : 4'd0;
                if (match && (good_q + 4'd1 == LOCK_RUN)) begin
                    state_d = ST_LOCK;
                    ref_d   = data_in_i;
                    bad_d   = 4'd0;
                end
            end else begin
                ref_d      = exp_word;
                err_bits_d = pop;
                err_d      = |diff;
                word_cnt_d = (word_cnt_q == CNT_MAX) ? CNT_MAX : word_cnt_q + 1'b1;
                err_cnt_d  = (err_sum > {6'b0, CNT_MAX}) ? CNT_MAX : err_sum[CNT_W-1:0];
                bad_d      = (|diff) ? bad_q + 4'd1 : 4'd0;
                if ((|diff) && (bad_q + 4'd1 == BAD_RUN)) begin
                    state_d = ST_HUNT;
                    good_d  = 4'd0;
                    bad_d   = 4'd0;
                    prev_d  = data_in_i;
                end
            end
        end

        // Clearing wins over the word counted in the same cycle.
        if (clr_cnt_i) begin
            err_cnt_d  = '0;
            word_cnt_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_HUNT;
            good_q     <= 4'd0;
            bad_q      <= 4'd0;
            prev_q     <= '0;
            ref_q      <= '0;
            err_q      <= 1'b0;
            err_bits_q <= 6'd0;
            err_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            prev_q     <= prev_d;
            ref_q      <= ref_d;
            err_q      <= err_d;
            err_bits_q <= err_bits_d;
            err_cnt_q  <= err_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign locked_o   = (state_q == ST_LOCK);
    assign err_o      = err_q;
    assign err_bits_o = err_bits_q;
    assign err_cnt_o  = err_cnt_q;
    assign word_cnt_o = word_cnt_q;

endmodule
